// File: rtl/xil_mem_pkg.sv
// xil_mem_pkg: shared helpers for the arbitrated block-RAM slice.
// Write-mode names, address-width function and parameter checks.
package xil_mem_pkg;

  localparam string WM_WRITE_FIRST = "WRITE_FIRST";
  localparam string WM_READ_FIRST  = "READ_FIRST";
  localparam string WM_NO_CHANGE   = "NO_CHANGE";

  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    n = 0;
    while (d > 0) begin
      d = d >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic bit read_latency_ok(input int rl);
    return (rl == 1) || (rl == 2);
  endfunction

endpackage

// File: rtl/xil_rr_arbiter.sv
// xil_rr_arbiter: combinational one-hot round-robin grant.
// The pointer moves past the winner only when advance is set.
module xil_rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] nxt;
  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    nxt = ptr;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        nxt      = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/xil_arb_sp_ram.sv
// xil_arb_sp_ram: NUM_PORTS requesters sharing one byte-write
// single-port block RAM through a round-robin arbiter.
module xil_arb_sp_ram
  import xil_mem_pkg::*;
#(
  parameter  int    NUM_PORTS    = 2,
  parameter  int    NB_COL       = 4,
  parameter  int    COL_WIDTH    = 8,
  parameter  int    RAM_DEPTH    = 2048,
  parameter  int    READ_LATENCY = 1,
  parameter  string WRITE_MODE   = WM_WRITE_FIRST,
  parameter  string INIT_FILE    = "",
  localparam int    AW           = clogb2(RAM_DEPTH - 1),
  localparam int    DW           = NB_COL * COL_WIDTH
) (
  input  logic                        clka,
  input  logic                        rsta_n,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  input  logic [NUM_PORTS*NB_COL-1:0] be_i,
  input  logic [NUM_PORTS*AW-1:0]     addr_i,
  input  logic [NUM_PORTS*DW-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        rvalid_o,
  output logic [NUM_PORTS*DW-1:0]     rdata_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam bit WF = (WRITE_MODE == WM_WRITE_FIRST);
  localparam bit NC = (WRITE_MODE == WM_NO_CHANGE);
  localparam bit RF = (WRITE_MODE == WM_READ_FIRST);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_rl
    $error("xil_arb_sp_ram: READ_LATENCY must be 1 or 2");
  end
  if (!(WF || NC || RF)) begin : g_bad_wm
    $error("xil_arb_sp_ram: unknown WRITE_MODE");
  end

  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        ptr_unused;
  logic                 any;

  assign any   = |req_i;
  assign gnt_o = gnt;

  xil_rr_arbiter #(
    .N (NUM_PORTS)
  ) u_arb (
    .clk     (clka),
    .rst_n   (rsta_n),
    .req     (req_i),
    .advance (any),
    .gnt     (gnt),
    .ptr     (ptr_unused)
  );

  logic [PW-1:0]     sel;
  logic              s_we;
  logic [NB_COL-1:0] s_be;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;

  always_comb begin
    sel     = '0;
    s_we    = 1'b0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) begin
        sel     = PW'(k);
        s_we    = we_i[k];
        s_be    = be_i[k*NB_COL +: NB_COL];
        s_addr  = addr_i[k*AW +: AW];
        s_wdata = wdata_i[k*DW +: DW];
      end
    end
  end

  logic [DW-1:0] mem [RAM_DEPTH];
  logic [DW-1:0] merged;
  logic [DW-1:0] rd_q;

  initial for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;

  always_comb begin
    merged = mem[s_addr];
    for (int c = 0; c < NB_COL; c++) begin
      if (s_be[c]) merged[c*COL_WIDTH +: COL_WIDTH] = s_wdata[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  // Array is never reset; nothing commits while reset is asserted.
  always_ff @(posedge clka) begin
    if (rsta_n && any) begin
      rd_q <= (s_we && WF) ? merged : mem[s_addr];
      for (int c = 0; c < NB_COL; c++) begin
        if (s_we && s_be[c]) begin
          mem[s_addr][c*COL_WIDTH +: COL_WIDTH] <= s_wdata[c*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  logic          v1;
  logic [PW-1:0] p1;
  logic          w1;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      v1 <= 1'b0;
      p1 <= '0;
      w1 <= 1'b0;
    end else begin
      v1 <= any;
      if (any) begin
        p1 <= sel;
        w1 <= s_we;
      end
    end
  end

  logic          vl;
  logic [PW-1:0] pl;
  logic          wl;
  logic [DW-1:0] dl;

  if (READ_LATENCY == 2) begin : g_rl2
    logic          v2;
    logic [PW-1:0] p2;
    logic          w2;
    logic [DW-1:0] d2;

    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
        v2 <= 1'b0;
        p2 <= '0;
        w2 <= 1'b0;
      end else begin
        v2 <= v1;
        p2 <= p1;
        w2 <= w1;
      end
    end

    always_ff @(posedge clka) begin
      d2 <= rd_q;
    end

    assign vl = v2;
    assign pl = p2;
    assign wl = w2;
    assign dl = d2;
  end else begin : g_rl1
    assign vl = v1;
    assign pl = p1;
    assign wl = w1;
    assign dl = rd_q;
  end

  logic [NUM_PORTS*DW-1:0] hold_q;

  // rdata_o shows the new word in the rvalid cycle, then holds it.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = hold_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rvalid_o[k] = vl && (pl == PW'(k));
      if (rvalid_o[k] && !(NC && wl)) rdata_o[k*DW +: DW] = dl;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= rdata_o;
    end
  end

endmodule

// File: tb/tb_xil_arb_sp_ram.sv
// tb_xil_arb_sp_ram: directed plus random traffic on two ports,
// compared against an array/queue reference model.
module tb_xil_arb_sp_ram;

  parameter int    RL = 1;
  parameter string WM = "WRITE_FIRST";

  localparam int NP    = 2;
  localparam int NBC   = 4;
  localparam int CW    = 8;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int DW    = 32;

  logic clka = 1'b0;
  logic rsta_n = 1'b0;

  logic [NP-1:0]     req_i;
  logic [NP-1:0]     we_i;
  logic [NP*NBC-1:0] be_i;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     rvalid_o;
  logic [NP*DW-1:0]  rdata_o;

  logic           p_req   [NP];
  logic           p_we    [NP];
  logic [NBC-1:0] p_be    [NP];
  logic [AW-1:0]  p_addr  [NP];
  logic [DW-1:0]  p_wdata [NP];

  always #5 clka = ~clka;

  always_comb begin
    req_i   = '0;
    we_i    = '0;
    be_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    for (int k = 0; k < NP; k++) begin
      req_i[k]             = p_req[k];
      we_i[k]              = p_we[k];
      be_i[k*NBC +: NBC]   = p_be[k];
      addr_i[k*AW +: AW]   = p_addr[k];
      wdata_i[k*DW +: DW]  = p_wdata[k];
    end
  end

  xil_arb_sp_ram #(
    .NUM_PORTS    (NP),
    .NB_COL       (NBC),
    .COL_WIDTH    (CW),
    .RAM_DEPTH    (DEPTH),
    .READ_LATENCY (RL),
    .WRITE_MODE   (WM),
    .INIT_FILE    ("")
  ) dut (
    .clka     (clka),
    .rsta_n   (rsta_n),
    .req_i    (req_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o)
  );

  typedef struct {
    int            due;
    int            port;
    bit            nc;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] mref   [DEPTH];
  logic [DW-1:0] exp_rd [NP];
  rsp_t          rsp_q  [$];
  bit            acc    [NP];
  int            ptr;
  int            cyc;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < NP; i++) begin
      if (p_req[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return -1;
  endfunction

  task automatic step();
    int            g;
    int            rp;
    logic [NP-1:0] eg;
    logic [NP-1:0] ev;
    logic [DW-1:0] old;
    logic [DW-1:0] nw;
    #1;
    if (!rsta_n) begin
      rsp_q.delete();
      ptr = 0;
      for (int k = 0; k < NP; k++) exp_rd[k] = '0;
    end
    g  = pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", gnt_o, eg);
    ev = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      rp     = rsp_q[0].port;
      ev[rp] = 1'b1;
      if (!rsp_q[0].nc) exp_rd[rp] = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    chk("rvalid", rvalid_o, ev);
    for (int k = 0; k < NP; k++) chk("rdata", rdata_o[k*DW +: DW], exp_rd[k]);
    for (int k = 0; k < NP; k++) acc[k] = 1'b0;
    @(posedge clka);
    if (rsta_n && g >= 0) begin
      old = mref[p_addr[g]];
      nw  = old;
      for (int c = 0; c < NBC; c++) begin
        if (p_be[g][c]) nw[c*CW +: CW] = p_wdata[g][c*CW +: CW];
      end
      rsp_q.push_back('{due: cyc + RL, port: g,
                        nc: (p_we[g] && WM == "NO_CHANGE"),
                        data: (p_we[g] && WM == "WRITE_FIRST") ? nw : old});
      if (p_we[g]) mref[p_addr[g]] = nw;
      ptr    = (g + 1) % NP;
      acc[g] = 1'b1;
    end
    cyc++;
    @(negedge clka);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input int k, input bit we, input logic [NBC-1:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n          = 0;
    p_req[k]   = 1'b1;
    p_we[k]    = we;
    p_be[k]    = be;
    p_addr[k]  = a;
    p_wdata[k] = d;
    do begin
      step();
      n++;
    end while (!acc[k] && n < 20);
    chk("issue_granted", 64'(acc[k]), 64'd1);
    p_req[k] = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] save;
    total = 0;
    bad   = 0;
    ptr   = 0;
    cyc   = 0;
    for (int i = 0; i < DEPTH; i++) mref[i] = '0;
    for (int k = 0; k < NP; k++) begin
      exp_rd[k]  = '0;
      acc[k]     = 1'b0;
      p_req[k]   = 1'b1;
      p_we[k]    = 1'b0;
      p_be[k]    = '0;
      p_addr[k]  = AW'(k);
      p_wdata[k] = '0;
    end
    rsta_n = 1'b0;
    @(negedge clka);

    repeat (3) begin
      #1;
      chk("rst_gnt", gnt_o, 64'h1);
      chk("rst_rvalid", rvalid_o, 64'h0);
      chk("rst_rdata", rdata_o, 64'h0);
      step();
    end
    rsta_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_gnt", gnt_o, (i % 2 == 0) ? 64'h1 : 64'h2);
      step();
      for (int k = 0; k < NP; k++) begin
        if (acc[k]) p_addr[k] = AW'($urandom % 16);
      end
    end
    for (int k = 0; k < NP; k++) p_req[k] = 1'b0;
    idle(RL + 1);

    save = exp_rd[1];
    issue(0, 1'b1, 4'hF, 11'd5, 32'hAABBCCDD);
    issue(1, 1'b1, 4'h5, 11'd5, 32'h11223344);
    idle(RL + 1);
    chk("bw_wresp", rdata_o[DW +: DW],
        (WM == "WRITE_FIRST") ? 32'hAA22CC44 :
        (WM == "READ_FIRST")  ? 32'hAABBCCDD : save);
    issue(0, 1'b0, 4'h0, 11'd5, '0);
    idle(RL + 1);
    chk("bw_read", rdata_o[DW-1:0], 32'hAA22CC44);

    issue(0, 1'b1, 4'hF, 11'd9, 32'h12345678);
    issue(0, 1'b0, 4'h0, 11'd9, '0);
    idle(RL + 1);
    chk("nc_rd", rdata_o[DW-1:0], 32'h12345678);
    issue(0, 1'b1, 4'hF, 11'd9, 32'hFFFFFFFF);
    idle(RL + 1);
    chk("nc_wresp", rdata_o[DW-1:0],
        (WM == "WRITE_FIRST") ? 32'hFFFFFFFF : 32'h12345678);
    issue(0, 1'b0, 4'h0, 11'd9, '0);
    idle(RL + 1);
    chk("nc_rd2", rdata_o[DW-1:0], 32'hFFFFFFFF);

    issue(0, 1'b0, 4'h0, 11'd5, '0);
    rsta_n = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid_o, 64'h0);
    step();
    rsta_n = 1'b1;
    idle(RL + 1);
    p_req[0] = 1'b1;
    p_req[1] = 1'b1;
    #1;
    chk("midrst_ptr", gnt_o, 64'h1);
    step();
    p_req[0] = 1'b0;
    step();
    p_req[1] = 1'b0;
    idle(RL + 1);

    issue(0, 1'b1, 4'hF, 11'h7FF, 32'h0000BEEF);
    issue(1, 1'b0, 4'h0, 11'h7FF, '0);
    idle(RL + 1);
    chk("raw", rdata_o[DW +: DW], 32'h0000BEEF);

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NP; k++) begin
        if (!p_req[k] || acc[k]) begin
          if ($urandom % 3 != 0) begin
            p_req[k]   = 1'b1;
            p_we[k]    = 1'($urandom % 2);
            p_be[k]    = NBC'($urandom);
            p_addr[k]  = ($urandom % 4 == 0) ? 11'h7FF : AW'($urandom % 8);
            p_wdata[k] = $urandom;
          end else begin
            p_req[k] = 1'b0;
          end
        end
      end
      rsta_n = !(c == 200);
      step();
    end
    rsta_n = 1'b1;
    for (int k = 0; k < NP; k++) p_req[k] = 1'b0;
    idle(RL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
